// File: rtl/cart_arb_if.sv
// Signal bundle between the cart_arb arbiter and its environment.
// It carries the CPU and DMA request ports, the cartridge interface side and the error pulse.
interface cart_arb_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic        cpu_ack;

   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  dma_dout;
   logic        dma_ack;

   logic [15:0] if_addr;
   logic [7:0]  if_din;
   logic        if_rd;
   logic        if_wr;
   logic [7:0]  if_dout;
   logic        if_busy;

   logic        err;

   // The arbiter itself connects through this modport.
   modport slave (
      input  cpu_addr, cpu_din, cpu_rd, cpu_wr,
      output cpu_dout, cpu_ack,
      input  dma_addr, dma_rd,
      output dma_dout, dma_ack,
      output if_addr, if_din, if_rd, if_wr,
      input  if_dout, if_busy,
      output err
   );

   // The requesters and the cartridge interface connect through this modport.
   modport master (
      output cpu_addr, cpu_din, cpu_rd, cpu_wr,
      input  cpu_dout, cpu_ack,
      output dma_addr, dma_rd,
      input  dma_dout, dma_ack,
      input  if_addr, if_din, if_rd, if_wr,
      output if_dout, if_busy,
      input  err
   );
endinterface

// File: rtl/cart_arb.sv
// Round-robin CPU/DMA arbiter in front of the cartridge bus interface.
// It issues one-cycle rd/wr strobes and acks the granted port, with a busy watchdog.
module cart_arb #(
   parameter int TIMEOUT = 16
) (
   input logic        clk_8m,
   input logic        rst,
   cart_arb_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_DMA = 1'b1
   } grant_t;

   state_t           state;
   grant_t           grant;
   grant_t           last_grant;
   logic             op_wr;
   logic [CNT_W-1:0] wd_cnt;

   logic       cpu_pend;
   logic       dma_pend;
   logic       pick_dma;
   logic       wait_done;
   logic [7:0] wait_rd_data;

   // NOTE: every variable written here gets a value on every path, so no latch is inferred.
   always_comb begin
      cpu_pend     = bus.cpu_rd | bus.cpu_wr;
      dma_pend     = bus.dma_rd;
      // DMA wins when it is alone, or on contention when the CPU was served last.
      pick_dma     = dma_pend & (~cpu_pend | (last_grant == GRANT_CPU));
      wait_done    = ~bus.if_busy | (wd_cnt == WD_LAST);
      // A watchdog abort hands back all-ones instead of whatever the bus is showing.
      wait_rd_data = bus.if_busy ? 8'hFF : bus.if_dout;
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_8m) begin
      if (rst) begin
         state        <= IDLE;
         grant        <= GRANT_CPU;
         last_grant   <= GRANT_CPU;
         op_wr        <= 1'b0;
         wd_cnt       <= '0;
         bus.if_addr  <= 16'h0000;
         bus.if_din   <= 8'h00;
         bus.if_rd    <= 1'b0;
         bus.if_wr    <= 1'b0;
         bus.cpu_dout <= 8'hFF;
         bus.dma_dout <= 8'hFF;
         bus.cpu_ack  <= 1'b0;
         bus.dma_ack  <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.cpu_ack <= 1'b0;
         bus.dma_ack <= 1'b0;
         bus.err     <= 1'b0;

         case (state)
            IDLE: begin
               // A busy interface in IDLE is left over from elsewhere; hold off until it clears.
               if (!bus.if_busy && (cpu_pend || dma_pend)) begin
                  if (pick_dma) begin
                     grant       <= GRANT_DMA;
                     last_grant  <= GRANT_DMA;
                     op_wr       <= 1'b0;
                     bus.if_addr <= bus.dma_addr;
                     bus.if_rd   <= 1'b1;
                  end else begin
                     grant       <= GRANT_CPU;
                     last_grant  <= GRANT_CPU;
                     op_wr       <= ~bus.cpu_rd;
                     bus.if_addr <= bus.cpu_addr;
                     bus.if_din  <= bus.cpu_din;
                     bus.if_rd   <= bus.cpu_rd;
                     bus.if_wr   <= ~bus.cpu_rd;
                  end
                  state <= ISSUE;
               end
            end

            ISSUE: begin
               bus.if_rd <= 1'b0;
               bus.if_wr <= 1'b0;
               wd_cnt    <= '0;
               state     <= WAIT;
            end

            WAIT: begin
               if (wait_done) begin
                  if (!op_wr) begin
                     if (grant == GRANT_DMA) bus.dma_dout <= wait_rd_data;
                     else                    bus.cpu_dout <= wait_rd_data;
                  end
                  if (grant == GRANT_DMA) bus.dma_ack <= 1'b1;
                  else                    bus.cpu_ack <= 1'b1;
                  bus.err <= bus.if_busy;
                  state   <= DONE;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cart_arb.sv
// Directed bench for cart_arb with a 4-cycle cartridge interface model.
// Expected values are hand-computed from the arbiter timing: strobe at N+1, ack at N+6.
`timescale 1ns/100ps
module tb_cart_arb;

   logic clk_8m = 1'b0;
   logic rst    = 1'b1;
   logic stuck  = 1'b0;
   logic [1:0] busy_cnt;

   int vectors    = 0;
   int miscompares = 0;

   cart_arb_if bus ();

   cart_arb #(.TIMEOUT(16)) dut (
      .clk_8m (clk_8m),
      .rst    (rst),
      .bus    (bus)
   );

   always #62.5 clk_8m = ~clk_8m;

   // Cartridge interface model: busy while strobed and for three cycles after.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return (a[15:8] == 8'h40) ? 8'h5A : (a[7:0] + 8'hC3);
   endfunction

   always @(posedge clk_8m) begin
      if (rst)                        busy_cnt <= 2'd0;
      else if (bus.if_rd | bus.if_wr) busy_cnt <= 2'd3;
      else if (busy_cnt != 2'd0)      busy_cnt <= busy_cnt - 2'd1;
   end

   assign bus.if_busy = bus.if_rd | bus.if_wr | (busy_cnt != 2'd0) | stuck;
   assign bus.if_dout = mem_byte(bus.if_addr);

   task automatic tick();
      @(posedge clk_8m);
      #1;
   endtask

   task automatic apply_reset();
      rst        = 1'b1;
      bus.cpu_rd = 1'b0;
      bus.cpu_wr = 1'b0;
      bus.dma_rd = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({bus.if_rd, bus.if_wr, bus.cpu_ack, bus.dma_ack, bus.err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_pulses: got %b want 00000",
                  {bus.if_rd, bus.if_wr, bus.cpu_ack, bus.dma_ack, bus.err});
      end
      vectors++;
      if ({bus.if_addr, bus.if_din} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_if_bus: got %h want 000000", {bus.if_addr, bus.if_din});
      end
      vectors++;
      if ({bus.cpu_dout, bus.dma_dout} !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL reset_dout: got %h want ffff", {bus.cpu_dout, bus.dma_dout});
      end
   endtask

   // One CPU access from IDLE; checks strobe timing, address, ack cycle and returned data.
   task automatic cpu_access(input string name, input logic [15:0] addr, input logic [7:0] din,
                             input logic rd, input logic wr, input logic [7:0] exp_dout);
      int rd_n = 0, wr_n = 0, dma_n = 0, ack_at = -1;
      logic exp_rd;
      exp_rd = rd;
      bus.cpu_addr = addr;
      bus.cpu_din  = din;
      bus.cpu_rd   = rd;
      bus.cpu_wr   = wr;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (bus.if_rd) rd_n++;
         if (bus.if_wr) wr_n++;
         if (bus.dma_ack) dma_n++;
         if (c == 1) begin
            vectors++;
            if ({bus.if_rd, bus.if_wr, bus.if_addr} !== {exp_rd, ~exp_rd, addr}) begin
               miscompares++;
               $display("FAIL %s_strobe: got rd=%b wr=%b addr=%h want rd=%b wr=%b addr=%h",
                        name, bus.if_rd, bus.if_wr, bus.if_addr, exp_rd, ~exp_rd, addr);
            end
            if (!exp_rd) begin
               vectors++;
               if (bus.if_din !== din) begin
                  miscompares++;
                  $display("FAIL %s_if_din: got %h want %h", name, bus.if_din, din);
               end
            end
         end
         if (bus.cpu_ack) begin
            if (ack_at < 0) ack_at = c;
            vectors++;
            if (bus.cpu_dout !== exp_dout) begin
               miscompares++;
               $display("FAIL %s_dout: got %h want %h", name, bus.cpu_dout, exp_dout);
            end
            bus.cpu_rd = 1'b0;
            bus.cpu_wr = 1'b0;
         end
      end
      vectors++;
      if (ack_at !== 6) begin
         miscompares++;
         $display("FAIL %s_ack_cycle: got %0d want 6", name, ack_at);
      end
      vectors++;
      if ({rd_n, wr_n} !== {exp_rd ? 32'd1 : 32'd0, exp_rd ? 32'd0 : 32'd1}) begin
         miscompares++;
         $display("FAIL %s_strobe_count: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                  name, rd_n, wr_n, exp_rd ? 1 : 0, exp_rd ? 0 : 1);
      end
      vectors++;
      if (dma_n !== 0) begin
         miscompares++;
         $display("FAIL %s_dma_ack: got %0d pulses want 0", name, dma_n);
      end
   endtask

   task automatic test_cpu_write();
      cpu_access("cpu_write", 16'h2000, 8'h03, 1'b0, 1'b1, 8'hFF);
   endtask

   task automatic test_cpu_read();
      cpu_access("cpu_read", 16'h4000, 8'h00, 1'b1, 1'b0, 8'h5A);
      cpu_access("cpu_rdwr", 16'h1234, 8'h77, 1'b1, 1'b1, 8'hF7);
   endtask

   task automatic test_fairness();
      byte who[$];
      int  at[$];
      byte exp_who[4] = '{"D", "C", "D", "C"};
      int  exp_at[4]  = '{6, 13, 20, 27};
      apply_reset();
      bus.cpu_addr = 16'h4000;
      bus.cpu_rd   = 1'b1;
      bus.dma_addr = 16'h0010;
      bus.dma_rd   = 1'b1;
      for (int c = 1; c <= 27; c++) begin
         tick();
         if (bus.cpu_ack && bus.dma_ack) begin
            vectors++;
            miscompares++;
            $display("FAIL fair_double_ack: both acks high at cycle %0d", c);
         end
         if (bus.dma_ack) begin
            who.push_back("D");
            at.push_back(c);
            vectors++;
            if (bus.dma_dout !== 8'hD3) begin
               miscompares++;
               $display("FAIL fair_dma_dout: got %h want d3", bus.dma_dout);
            end
         end
         if (bus.cpu_ack) begin
            who.push_back("C");
            at.push_back(c);
            vectors++;
            if (bus.cpu_dout !== 8'h5A) begin
               miscompares++;
               $display("FAIL fair_cpu_dout: got %h want 5a", bus.cpu_dout);
            end
         end
      end
      bus.cpu_rd = 1'b0;
      bus.dma_rd = 1'b0;
      tick();
      vectors++;
      if (who.size() !== 4) begin
         miscompares++;
         $display("FAIL fair_count: got %0d acks want 4", who.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (who[i] !== exp_who[i] || at[i] !== exp_at[i]) begin
               miscompares++;
               $display("FAIL fair_order[%0d]: got %s@%0d want %s@%0d",
                        i, who[i], at[i], exp_who[i], exp_at[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_data[4] = '{8'hC3, 8'hC4, 8'hC5, 8'hC6};
      int strobe_at[4] = '{0, 0, 0, 0};
      int strobes = 0, acks = 0, cpu_n = 0;
      bus.dma_addr = 16'h0000;
      bus.dma_rd   = 1'b1;
      for (int c = 1; c <= 40 && acks < 4; c++) begin
         tick();
         if (bus.cpu_ack) cpu_n++;
         if (bus.if_rd) begin
            if (strobes < 4) strobe_at[strobes] = c;
            strobes++;
         end
         if (bus.dma_ack) begin
            vectors++;
            if (bus.dma_dout !== exp_data[acks] || strobes !== acks + 1) begin
               miscompares++;
               $display("FAIL b2b_ack[%0d]: got dout=%h strobes=%0d want dout=%h strobes=%0d",
                        acks, bus.dma_dout, strobes, exp_data[acks], acks + 1);
            end
            acks++;
            if (acks < 4) bus.dma_addr = 16'(acks);
            else          bus.dma_rd   = 1'b0;
         end
      end
      tick();
      vectors++;
      if (acks !== 4 || cpu_n !== 0) begin
         miscompares++;
         $display("FAIL b2b_count: got acks=%0d cpu_acks=%0d want 4 and 0", acks, cpu_n);
      end
      for (int i = 1; i < 4; i++) begin
         vectors++;
         if (strobe_at[i] - strobe_at[i-1] !== 7) begin
            miscompares++;
            $display("FAIL b2b_spacing[%0d]: got %0d want 7", i, strobe_at[i] - strobe_at[i-1]);
         end
      end
   endtask

   task automatic test_watchdog();
      int err_at = -1, ack_at = -1, err_n = 0, rd_n = 0, dack_at = -1;
      bus.cpu_addr = 16'h4000;
      bus.cpu_rd   = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         if (c == 1) stuck = 1'b1;
         if (bus.if_rd) rd_n++;
         if (bus.err) begin
            err_n++;
            if (err_at < 0) err_at = c;
         end
         if (bus.cpu_ack) begin
            if (ack_at < 0) ack_at = c;
            vectors++;
            if (bus.cpu_dout !== 8'hFF) begin
               miscompares++;
               $display("FAIL wd_dout: got %h want ff", bus.cpu_dout);
            end
            bus.cpu_rd = 1'b0;
         end
      end
      // WAIT is entered at cycle 2, so the abort lands 16 cycles later.
      vectors++;
      if ({err_at, ack_at, err_n, rd_n} !== {32'd18, 32'd18, 32'd1, 32'd1}) begin
         miscompares++;
         $display("FAIL wd_timing: got err@%0d ack@%0d errs=%0d rds=%0d want 18 18 1 1",
                  err_at, ack_at, err_n, rd_n);
      end
      bus.dma_addr = 16'h0003;
      bus.dma_rd   = 1'b1;
      rd_n = 0;
      repeat (4) begin
         tick();
         if (bus.if_rd) rd_n++;
      end
      vectors++;
      if (rd_n !== 0) begin
         miscompares++;
         $display("FAIL wd_stale_busy: got %0d strobes want 0", rd_n);
      end
      stuck = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (bus.dma_ack) begin
            if (dack_at < 0) dack_at = c;
            vectors++;
            if (bus.dma_dout !== 8'hC6) begin
               miscompares++;
               $display("FAIL wd_recover_dout: got %h want c6", bus.dma_dout);
            end
            bus.dma_rd = 1'b0;
         end
      end
      vectors++;
      if (dack_at !== 6) begin
         miscompares++;
         $display("FAIL wd_recover_ack: got %0d want 6", dack_at);
      end
   endtask

   task automatic test_reset_mid_op();
      int act_n = 0;
      bus.cpu_addr = 16'h4000;
      bus.cpu_rd   = 1'b1;
      repeat (3) tick();
      rst        = 1'b1;
      bus.cpu_rd = 1'b0;
      tick();
      vectors++;
      if ({bus.if_rd, bus.if_wr, bus.cpu_ack, bus.dma_ack, bus.err, bus.cpu_dout} !== {5'b0, 8'hFF}) begin
         miscompares++;
         $display("FAIL midrst_outputs: got %b/%h want 00000/ff",
                  {bus.if_rd, bus.if_wr, bus.cpu_ack, bus.dma_ack, bus.err}, bus.cpu_dout);
      end
      rst = 1'b0;
      repeat (8) begin
         tick();
         if (bus.if_rd | bus.if_wr | bus.cpu_ack | bus.dma_ack | bus.err) act_n++;
      end
      vectors++;
      if (act_n !== 0) begin
         miscompares++;
         $display("FAIL midrst_quiet: got %0d active cycles want 0", act_n);
      end
      cpu_access("midrst_read", 16'h1234, 8'h00, 1'b1, 1'b0, 8'hF7);
   endtask

   initial begin
      bus.cpu_addr = 16'h0000;
      bus.cpu_din  = 8'h00;
      bus.cpu_rd   = 1'b0;
      bus.cpu_wr   = 1'b0;
      bus.dma_addr = 16'h0000;
      bus.dma_rd   = 1'b0;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_fairness();
      test_back_to_back();
      test_watchdog();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #(125 * 5000);
      $display("FAIL global_timeout: simulation did not finish within 5000 cycles");
      $fatal(1);
   end

endmodule
